// File: rtl/ibex_ibus_arbiter.sv
// Two-master instruction-bus arbiter with in-order response routing via an ID FIFO.
// Build option: define IBEX_IBUS_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties) instead of round-robin.
module ibex_ibus_arbiter #(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [1:0]       m_req_i,
   input  logic [1:0][31:0] m_addr_i,
   output logic [1:0]       m_gnt_o,
   output logic [1:0]       m_rvalid_o,
   output logic [31:0]      m_rdata_o,
   output logic             m_err_o,
   output logic             instr_req_o,
   output logic [31:0]      instr_addr_o,
   input  logic             instr_gnt_i,
   input  logic             instr_rvalid_i,
   input  logic [31:0]      instr_rdata_i,
   input  logic             instr_err_i,
   output logic             busy_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_e;

   state_e                    state_q, state_d;
   logic                      sel_q, sel_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic [MaxOutstanding-1:0] ids_q, ids_d;
   logic [CntW-1:0]           widx;
   logic                      sel, full, push, pop;
`ifndef IBEX_IBUS_ARB_FIXED_PRIO_EN
   logic                      last_q, last_d;
`endif

   // Selection: frozen while locked, otherwise arbitrate among requesters
   always_comb begin
      sel = 1'b0;
      if (state_q == LOCKED) begin
         sel = sel_q;
      end else begin
         case (m_req_i)
            2'b10:   sel = 1'b1;
`ifdef IBEX_IBUS_ARB_FIXED_PRIO_EN
            2'b11:   sel = 1'b0;
`else
            2'b11:   sel = ~last_q;
`endif
            default: sel = 1'b0;
         endcase
      end
   end

   assign full         = (cnt_q == CntW'(MaxOutstanding));
   assign instr_req_o  = ~rst_i & m_req_i[sel] & ~full;
   assign instr_addr_o = m_addr_i[sel] & ~32'd3;
   assign push         = instr_req_o & instr_gnt_i;
   assign pop          = instr_rvalid_i & (cnt_q != '0);
   assign m_gnt_o      = push ? (sel ? 2'b10 : 2'b01) : 2'b00;
   assign m_rvalid_o   = pop ? (ids_q[0] ? 2'b10 : 2'b01) : 2'b00;
   assign m_rdata_o    = instr_rdata_i;
   assign m_err_o      = instr_err_i;
   assign busy_o       = (cnt_q != '0) | instr_req_o;

   // Next-state: lock onto a stalled request until granted or abandoned
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: begin
            if (instr_req_o && !instr_gnt_i) begin
               state_d = LOCKED;
               sel_d   = sel;
            end
         end
         LOCKED: begin
            if (push || !m_req_i[sel_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ID FIFO as a shift register: head at index 0, new entry written behind the tail
   always_comb begin
      ids_d = ids_q;
      widx  = cnt_q;
      if (pop) begin
         ids_d = ids_q >> 1;
         widx  = cnt_q - CntW'(1);
      end
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
         if (push && (widx == CntW'(i))) begin
            ids_d[i] = sel;
         end
      end
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
   end

`ifndef IBEX_IBUS_ARB_FIXED_PRIO_EN
   assign last_d = push ? sel : last_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         cnt_q   <= '0;
         ids_q   <= '0;
`ifndef IBEX_IBUS_ARB_FIXED_PRIO_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         ids_q   <= ids_d;
`ifndef IBEX_IBUS_ARB_FIXED_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

endmodule

// File: tb/tb_ibex_ibus_arbiter.sv
// Randomized self-checking bench for ibex_ibus_arbiter against a queue-based reference model.
module tb_ibex_ibus_arbiter;

   localparam int unsigned MAX = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       m_req;
   logic [1:0][31:0] m_addr;
   logic [1:0]       m_gnt, m_rvalid;
   logic [31:0]      m_rdata;
   logic             m_err;
   logic             instr_req;
   logic [31:0]      instr_addr;
   logic             instr_gnt, instr_rvalid, instr_err;
   logic [31:0]      instr_rdata;
   logic             busy;

   always #5 clk = ~clk;

   ibex_ibus_arbiter #(.MaxOutstanding(MAX)) dut (
      .clk_i(clk), .rst_i(rst), .m_req_i(m_req), .m_addr_i(m_addr),
      .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
      .instr_req_o(instr_req), .instr_addr_o(instr_addr), .instr_gnt_i(instr_gnt),
      .instr_rvalid_i(instr_rvalid), .instr_rdata_i(instr_rdata), .instr_err_i(instr_err),
      .busy_o(busy)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: lock flag, locked master, last granted master, queue of outstanding IDs
   bit   mdl_locked;
   bit   mdl_lm;
   bit   mdl_last;
   bit   mdl_q[$];
   bit   exp_sel;
   logic exp_req, exp_busy;
   logic [1:0]  exp_gnt, exp_rv;
   logic [31:0] exp_addr;

   function automatic void model_reset();
      mdl_locked = 1'b0;
      mdl_lm     = 1'b0;
      mdl_last   = 1'b1;
      mdl_q.delete();
   endfunction

   function automatic void model_eval();
      if (mdl_locked) exp_sel = mdl_lm;
      else if (m_req == 2'b11) begin
`ifdef IBEX_IBUS_ARB_FIXED_PRIO_EN
         exp_sel = 1'b0;
`else
         exp_sel = !mdl_last;
`endif
      end else exp_sel = (m_req == 2'b10);
      exp_req  = !rst && m_req[exp_sel] && (mdl_q.size() < MAX);
      exp_addr = {m_addr[exp_sel][31:2], 2'b00};
      exp_gnt  = (exp_req && instr_gnt) ? (2'b01 << exp_sel) : 2'b00;
      exp_rv   = (!rst && instr_rvalid && mdl_q.size() > 0) ? (2'b01 << mdl_q[0]) : 2'b00;
      exp_busy = !rst && (mdl_q.size() > 0 || exp_req);
   endfunction

   function automatic void model_update();
      bit do_push;
      if (rst) begin
         model_reset();
         return;
      end
      do_push = exp_req && instr_gnt;
      if (instr_rvalid && mdl_q.size() > 0) void'(mdl_q.pop_front());
      if (do_push) begin
         mdl_q.push_back(exp_sel);
         mdl_last = exp_sel;
      end
      if (!mdl_locked) begin
         if (exp_req && !instr_gnt) begin
            mdl_locked = 1'b1;
            mdl_lm     = exp_sel;
         end
      end else if (do_push || !m_req[mdl_lm]) begin
         mdl_locked = 1'b0;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle's inputs, then compare every output with the model
   task automatic drive(input logic r, input logic [1:0] rq, input logic [31:0] a0,
                        input logic [31:0] a1, input logic g, input logic rv,
                        input logic [31:0] rd, input logic e);
      @(negedge clk);
      rst = r; m_req = rq; m_addr[0] = a0; m_addr[1] = a1;
      instr_gnt = g; instr_rvalid = rv; instr_rdata = rd; instr_err = e;
      if (r) model_reset();
      #2;
      model_eval();
      chk("instr_req", 32'(instr_req), 32'(exp_req));
      chk("instr_addr", instr_addr, exp_addr);
      chk("m_gnt", 32'(m_gnt), 32'(exp_gnt));
      chk("m_rvalid", 32'(m_rvalid), 32'(exp_rv));
      chk("m_rdata", m_rdata, rd);
      chk("m_err", 32'(m_err), 32'(e));
      chk("busy", 32'(busy), 32'(exp_busy));
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
   endtask

   initial begin
      logic [1:0] rq;
      rst = 1'b1; m_req = '0; m_addr = '0; instr_gnt = 0; instr_rvalid = 0;
      instr_rdata = '0; instr_err = 0;
      model_reset();

      // Reset: bus request and grants held off, data passes through
      drive(1, 2'b11, 32'h10, 32'h20, 1, 1, 32'hDEAD0000, 1);
      chk("rst_req", 32'(instr_req), 32'd0);
      chk("rst_gnt", 32'(m_gnt), 32'd0);
      chk("rst_rvalid", 32'(m_rvalid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", m_rdata, 32'hDEAD0000);
      tick();
      drive(1, 2'b00, 0, 0, 0, 0, 0, 0); tick();

      // Both masters continuously requesting
      for (int i = 0; i < 4; i++) begin
         drive(0, 2'b11, 32'h1000, 32'h2000, 1, i > 0, 32'h0, 0);
`ifdef IBEX_IBUS_ARB_FIXED_PRIO_EN
         chk("alt_gnt", 32'(m_gnt), 32'h1);
`else
         chk("alt_gnt", 32'(m_gnt), (i % 2) ? 32'h2 : 32'h1);
`endif
         tick();
      end
      drive(0, 2'b00, 0, 0, 0, 1, 0, 0); tick();

      // Locked master 1 holds the bus address while stalled
      drive(0, 2'b10, 32'h200, 32'h100, 0, 0, 0, 0);
      chk("lock_addr0", instr_addr, 32'h100);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(0, 2'b11, 32'h200, 32'h100, 0, 0, 0, 0);
         chk("lock_addr", instr_addr, 32'h100);
         chk("lock_nogrant", 32'(m_gnt), 32'd0);
         tick();
      end
      drive(0, 2'b11, 32'h200, 32'h100, 1, 0, 0, 0);
      chk("lock_addr3", instr_addr, 32'h100);
      chk("lock_gnt_m1", 32'(m_gnt), 32'h2);
      tick();
      drive(0, 2'b11, 32'h200, 32'h100, 1, 0, 0, 0);
      chk("after_lock_m0", 32'(m_gnt), 32'h1);
      tick();
      drive(0, 2'b00, 0, 0, 0, 1, 0, 0); tick();
      drive(0, 2'b00, 0, 0, 0, 1, 0, 0); tick();

      // Outstanding limit stalls the bus until a response arrives
      drive(0, 2'b01, 32'h300, 0, 1, 0, 0, 0); chk("full_g1", 32'(m_gnt), 32'h1); tick();
      drive(0, 2'b01, 32'h304, 0, 1, 0, 0, 0); chk("full_g2", 32'(m_gnt), 32'h1); tick();
      drive(0, 2'b01, 32'h308, 0, 1, 0, 0, 0); chk("full_req0", 32'(instr_req), 32'd0); tick();
      drive(0, 2'b01, 32'h308, 0, 1, 1, 0, 0);
      chk("full_rv_req0", 32'(instr_req), 32'd0);
      chk("full_rv", 32'(m_rvalid), 32'h1);
      tick();
      drive(0, 2'b01, 32'h308, 0, 1, 0, 0, 0); chk("full_g3", 32'(m_gnt), 32'h1); tick();
      drive(0, 2'b00, 0, 0, 0, 1, 0, 0); tick();
      drive(0, 2'b00, 0, 0, 0, 1, 0, 0); tick();

      // Simultaneous grant and response keep ordering
      drive(0, 2'b01, 32'h400, 32'h500, 1, 0, 0, 0); chk("ord_g0", 32'(m_gnt), 32'h1); tick();
      drive(0, 2'b10, 32'h400, 32'h500, 1, 1, 32'h11111111, 0);
      chk("ord_g1", 32'(m_gnt), 32'h2);
      chk("ord_rv0", 32'(m_rvalid), 32'h1);
      tick();
      drive(0, 2'b00, 0, 0, 0, 1, 32'hCAFEF00D, 0);
      chk("ord_rv1", 32'(m_rvalid), 32'h2);
      chk("ord_data", m_rdata, 32'hCAFEF00D);
      chk("ord_busy", 32'(busy), 32'd1);
      tick();
      drive(0, 2'b00, 0, 0, 0, 0, 0, 0); chk("ord_idle", 32'(busy), 32'd0); tick();

      // Reset mid-flight discards outstanding tracking
      drive(0, 2'b11, 32'h600, 32'h700, 1, 0, 0, 0); tick();
      drive(0, 2'b11, 32'h600, 32'h700, 1, 0, 0, 0); tick();
      drive(1, 2'b00, 0, 0, 0, 0, 0, 0); tick();
      drive(0, 2'b00, 0, 0, 0, 1, 32'h5, 0);
      chk("prst_rv", 32'(m_rvalid), 32'd0);
      chk("prst_busy", 32'(busy), 32'd0);
      tick();
      drive(0, 2'b11, 32'h600, 32'h700, 1, 0, 0, 0); chk("prst_tie", 32'(m_gnt), 32'h1); tick();
      drive(0, 2'b00, 0, 0, 0, 1, 0, 0); tick();

      // Spurious response while idle
      drive(0, 2'b00, 0, 0, 0, 1, 32'hBAD, 1);
      chk("spur_rv", 32'(m_rvalid), 32'd0);
      chk("spur_err", 32'(m_err), 32'd1);
      tick();
      drive(0, 2'b00, 0, 0, 0, 0, 0, 0); chk("spur_busy", 32'(busy), 32'd0); tick();

      // Random traffic
      rq = 2'b00;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) == 0) rq[0] = ~rq[0];
         if ($urandom_range(3) == 0) rq[1] = ~rq[1];
         drive($urandom_range(299) == 0, rq, $urandom, $urandom, 1'($urandom),
               $urandom_range(2) == 0, $urandom, 1'($urandom));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ibex_ibus_arbiter.md
IBEX_IBUS_ARBITER -- requirements
Module: ibex_ibus_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2 (range 1..4): maximum granted-but-unanswered bus transactions.
REQ-002 SHALL have ports `clk_i  in  1`: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `rst_i  in  1`: reset, asynchronous, active-high.
REQ-004 SHALL have port `m_req_i  in  2`: per-master request; master 0 = prefetch buffer, master 1 = secondary fetcher.
REQ-005 SHALL have port `m_addr_i  in  2x32`: per-master word address.
REQ-006 SHALL have port `m_gnt_o  out  2`: per-master grant.
REQ-007 SHALL have port `m_rvalid_o  out  2`: per-master response valid.
REQ-008 SHALL have ports `m_rdata_o  out  32` and `m_err_o  out  1`: response data and error, broadcast to both masters.
REQ-009 SHALL have port `instr_req_o  out  1`: shared bus request.
REQ-010 SHALL have port `instr_addr_o  out  32`: shared bus address, bits [1:0] forced to 0.
REQ-011 SHALL have ports `instr_gnt_i`, `instr_rvalid_i`, `instr_err_i` (each in, 1) and `instr_rdata_i` (in, 32): shared bus response side.
REQ-012 SHALL have port `busy_o  out  1`: high when outstanding count is non-zero or `instr_req_o` is high.

Function
REQ-013 SHALL implement a two-state FSM:
- IDLE: arbitrate among the asserted `m_req_i`.
- LOCKED: hold the selected master because its request is on the bus and not yet granted.
REQ-014 In IDLE, a single requester SHALL be selected outright; when both request, the master not granted most recently SHALL be selected (round-robin).
REQ-015 `instr_req_o` SHALL equal the selected master's `m_req_i` AND not-full; `instr_addr_o` SHALL be that master's `m_addr_i`, all combinational.
REQ-016 Grant handling SHALL be combinational with zero latency: `m_gnt_o[k]` = `instr_req_o` & `instr_gnt_i` & (selected == k).
REQ-017 IDLE->LOCKED when `instr_req_o` is high and `instr_gnt_i` is low; the selection is frozen while LOCKED.
REQ-018 LOCKED->IDLE on `instr_gnt_i`, or when the locked master drops its request (abort, no grant issued).
REQ-019 In LOCKED, the other master SHALL NOT be granted, even if the locked master is stalled by full.
REQ-020 Each grant SHALL push the granted master ID into an ID FIFO of depth MaxOutstanding and increment the outstanding count.
REQ-021 Each `instr_rvalid_i` SHALL pop the ID FIFO and decrement the count; `m_rvalid_o[head]` = `instr_rvalid_i`.
REQ-022 Grant and rvalid in the same cycle SHALL push and pop together: count unchanged, responses stay in order.
REQ-023 Full (count == MaxOutstanding) SHALL force `instr_req_o` low, even if rvalid arrives that cycle.
REQ-024 `instr_rvalid_i` with count 0 SHALL be ignored: no `m_rvalid_o`, count stays 0.
REQ-025 The round-robin pointer SHALL update only on a grant.

Reset
REQ-026 While `rst_i` is high, FSM = IDLE, count = 0, ID FIFO empty, and the last-granted pointer = master 1, so master 0 wins the first tie.
REQ-027 During reset, `instr_req_o`, `m_gnt_o`, `m_rvalid_o` and `busy_o` SHALL be 0; `m_rdata_o` and `m_err_o` pass through from the bus.
REQ-028 Reset asserted mid-transaction SHALL discard all outstanding tracking; responses arriving after reset SHALL be treated as per REQ-024.

Configuration
REQ-029 Macro `IBEX_IBUS_ARB_FIXED_PRIO_EN`:
- Defined: IDLE arbitration is fixed priority, master 0 always wins a tie, and the round-robin pointer is removed.
- Undefined: round-robin per REQ-014.
- LOCKED behaviour is identical in both builds.

Verification
REQ-030 Both masters request continuously, gnt=1, rvalid one cycle later -> grants alternate m0,m1,m0,m1; with the macro defined, m0 is granted every cycle.
REQ-031 m1 requests 0x100 with gnt held low 3 cycles while m0 also requests -> `instr_addr_o`=0x100 all 4 cycles, m0 not granted until the cycle after m1's grant.
REQ-032 MaxOutstanding=2, two grants with no rvalid -> `instr_req_o`=0 until the first rvalid; the third grant occurs one cycle after that rvalid.
REQ-033 Grant m0, then grant m1 in the same cycle as m0's rvalid -> `m_rvalid_o`=01, count stays 1; the next rvalid gives `m_rvalid_o`=10 with `m_rdata_o`=bus data.
REQ-034 `rst_i` pulsed with 2 outstanding, then rvalid -> `m_rvalid_o`=00, `busy_o`=0, next tie granted to m0.
REQ-035 Spurious rvalid at idle with `instr_err_i`=1 -> no `m_rvalid_o`, count stays 0.
